fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the program-counter register of the RV32I core. Every cycle it computes `pc_next` for the PC register and returns the current `pc` to it. It issues single-outstanding requests to instruction memory, buffers one fetched instruction for decode, and handles branch/jump redirects. This includes flushing an in-flight fetch and trapping misaligned targets.

## Interface
- `TRAP_VEC`, 32'h0000_0100, fetch address used when a redirect target is misaligned.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  current PC from the PC register, which resets to 0.
- `pc_next`  out  32  next PC, fed to the PC register and loaded every cycle.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equal to `pc`.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid; arrives at least 1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  branch/jump taken, 1-cycle pulse.
- `redirect_target`  in  32  redirect destination.
- `misalign_err`  out  1  redirect target had bits [1:0] != 0.
- `if_valid`  out  1  instruction buffer holds a valid instruction.
- `if_instr`  out  32  buffered instruction.
- `if_pc`  out  32  address of the buffered instruction.
- `id_ready`  in  1  decode consumes the buffer when `if_valid && id_ready`.

## Operation
- Control states: REQ, WAIT and FLUSH. The state is REQ in reset.
- Reset values: state=REQ, `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - `imem_req` is forced to 0 while `rst`=1.
  - `misalign_err` is 0 while `rst`=1.
  - `pc_next` equals `pc` while `rst`=1.
- `imem_req` = (state==REQ) && !`redirect_valid` && (!`if_valid` || `id_ready`).
- Transitions out of REQ:
  - `imem_req` && `imem_gnt` -> WAIT.
- Transitions out of WAIT:
  - `imem_rvalid` with no redirect: capture `if_instr`<=`imem_rdata`, `if_pc`<=`pc`, `if_valid`<=1; go to REQ.
- Transitions out of FLUSH:
  - `imem_rvalid`: discard the data; go to REQ.
- Buffer:
  - `if_valid` clears on consume (`if_valid && id_ready`) unless a capture occurs in the same cycle.
  - A capture in the same cycle as a consume leaves `if_valid`=1 holding the new data.
- `pc_next` priority, highest first:
  1. Redirect: `redirect_target`, or `TRAP_VEC` if `redirect_target[1:0]`!=0.
  2. WAIT && `imem_rvalid`: `pc`+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  3. Otherwise: `pc` (hold).
- Redirect in cycle t:
  - `if_valid`<=0 at t+1; a consume or capture in cycle t is overridden.
  - In REQ: `imem_req`=0 in cycle t; stay in REQ.
  - In WAIT with `imem_rvalid`: drop the data; go to REQ.
  - In WAIT without `imem_rvalid`: go to FLUSH.
  - In FLUSH without `imem_rvalid`: stay in FLUSH.
  - In FLUSH with `imem_rvalid`: go to REQ.
- `misalign_err` is combinational: `redirect_valid && redirect_target[1:0]`!=0, asserted in cycle t only.
- `imem_gnt` outside REQ, or while `imem_req`=0, is ignored.
- `imem_rvalid` in REQ is ignored.

## Timing
- Minimum fetch loop is 2 cycles: REQ with grant, then WAIT with rvalid on the following cycle.
- Sustained rate is one instruction per 2 cycles when memory grants immediately and responds next cycle.
- Captured instruction: `if_valid` high 1 cycle after the `imem_rvalid` edge; `pc` advances on the same edge.
- Redirect-to-new-request latency: the request with `imem_addr`=target is issued at t+1 if the state was REQ or (WAIT with rvalid).
  - Otherwise it is issued on the cycle after the stale response is discarded.
- Reset asserted mid-operation returns everything to reset values immediately; any outstanding memory response after release arrives in REQ and is ignored.
- Stall: with `if_valid`=1 and `id_ready`=0, `imem_req`=0 and `pc_next`=`pc` indefinitely.

## Test plan
- Reset release with `imem_gnt`=1 and `imem_rvalid`=1 one cycle later carrying 0x00000013 -> `if_valid`=1, `if_instr`=0x00000013, `if_pc`=0, `pc`=4; next `imem_addr`=4.
- Buffer full with `id_ready`=0 for 5 cycles at `pc`=8 -> `imem_req`=0 throughout, `pc_next`=8; raising `id_ready` asserts `imem_req` the same cycle.
- Redirect to 0x200 in WAIT before rvalid; stale rvalid 0xDEADBEEF 2 cycles later -> data not captured, `if_valid`=0, next request `imem_addr`=0x200.
- Redirect to 0x202 -> `misalign_err`=1 for one cycle, `pc_next`=0x100, next fetch at 0x100.
- Fetch at `pc`=0xFFFFFFFC -> `if_pc`=0xFFFFFFFC, `pc_next`=0x00000000.
- `rst` pulsed while in WAIT at `pc`=0x40 -> `if_valid`=0, `imem_req`=0 during reset; after release a late rvalid is ignored and the request goes out with `imem_addr`=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the RV32I core: drives the PC register's
// next value, issues single-outstanding instruction-memory requests, holds one
// fetched instruction for decode, and handles redirects, including flushing a
// fetch already in flight and trapping misaligned redirect targets.
module fetch_sequencer #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misalign_err,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    logic        target_misaligned;
    logic        capture;
    logic        consume;

    assign target_misaligned = redirect_target[1:0] != 2'b00;
    // A response lands in the buffer only if it answers a live fetch.
    assign capture = (state_q == WAIT) && imem_rvalid && !redirect_valid;
    assign consume = if_valid_q && id_ready;

    assign imem_addr = pc;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

    // Request, trap flag and next-PC selection; all are held quiet in reset.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        imem_req     = 1'b0;
        misalign_err = 1'b0;
        pc_next      = pc;
        if (!rst) begin
            imem_req     = (state_q == REQ) && !redirect_valid && (!if_valid_q || id_ready);
            misalign_err = redirect_valid && target_misaligned;
            if (redirect_valid) begin
                pc_next = target_misaligned ? TRAP_VEC : redirect_target;
            end else if ((state_q == WAIT) && imem_rvalid) begin
                pc_next = pc + 32'd4;
            end
        end
    end

    // Next-state logic for the fetch FSM and the one-entry instruction buffer.
    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        unique case (state_q)
            REQ: begin
                if (imem_req && imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                // A redirect before the response arrives leaves a stale beat to drain.
                if (imem_rvalid)         state_d = REQ;
                else if (redirect_valid) state_d = FLUSH;
            end
            FLUSH: begin
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        if (capture) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc;
        end

        // Redirect wins over capture, and capture wins over consume.
        if (redirect_valid)  if_valid_d = 1'b0;
        else if (capture)    if_valid_d = 1'b1;
        else if (consume)    if_valid_d = 1'b0;
    end

    // State and buffer registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this clock edge.
        if (rst) begin
            state_q    <= REQ;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'd0;
            if_pc_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: models the PC register around the DUT
// and walks through reset, basic fetch, stall, flush, trap, wrap and
// mid-operation reset with hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misalign_err;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    int n_vec = 0;
    int n_err = 0;

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misalign_err    (misalign_err),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .id_ready        (id_ready)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The PC register the controller drives: loads pc_next every cycle, resets to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= 32'd0;
        else     pc <= pc_next;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; registered outputs are stable there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after new inputs before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic redir, input logic [31:0] tgt, input logic rdy);
        imem_gnt        = gnt;
        imem_rvalid     = rv;
        imem_rdata      = rd;
        redirect_valid  = redir;
        redirect_target = tgt;
        id_ready        = rdy;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0202, 1'b1);
        tick();
        settle();
        // Reset: everything quiet even with grant, rvalid and a misaligned redirect present.
        check("rst_req",      {31'd0, imem_req},     32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check("rst_pc_next",  pc_next,               32'd0);
        check("rst_if_valid", {31'd0, if_valid},     32'd0);
        check("rst_if_instr", if_instr,              32'd0);
        check("rst_if_pc",    if_pc,                 32'd0);

        // Release reset, grant immediately.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        rst = 1'b0;
        settle();
        check("f0_req",     {31'd0, imem_req}, 32'd1);
        check("f0_addr",    imem_addr,         32'd0);
        check("f0_pc_next", pc_next,           32'd0);
        tick();
        // WAIT: response one cycle after grant.
        drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'd0, 1'b0);
        settle();
        check("f0_wait_req", {31'd0, imem_req}, 32'd0);
        check("f0_pc_inc",   pc_next,           32'd4);
        tick();
        check("f0_valid", {31'd0, if_valid}, 32'd1);
        check("f0_instr", if_instr,          32'h0000_0013);
        check("f0_if_pc", if_pc,             32'd0);
        check("f0_pc",    pc,                32'd4);
        check("f1_addr",  imem_addr,         32'd4);

        // Fetch at 4 while consuming the buffered instruction; decode then stalls.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        settle();
        check("f1_req", {31'd0, imem_req}, 32'd1);
        tick();
        check("f1_consumed", {31'd0, if_valid}, 32'd0);
        drive(1'b0, 1'b1, 32'h0010_0093, 1'b0, 32'd0, 1'b0);
        tick();
        check("f1_instr", if_instr, 32'h0010_0093);
        check("f1_if_pc", if_pc,    32'd4);
        check("f1_pc",    pc,       32'd8);

        // Stall: buffer full, decode not ready, grant offered every cycle.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_req",     {31'd0, imem_req}, 32'd0);
            check("stall_pc_next", pc_next,           32'd8);
            tick();
        end
        check("stall_valid", {31'd0, if_valid}, 32'd1);
        id_ready = 1'b1;
        settle();
        check("unstall_req",  {31'd0, imem_req}, 32'd1);
        check("unstall_addr", imem_addr,         32'd8);
        tick();

        // Redirect to 0x200 while waiting; stale response two cycles later.
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0200, 1'b1);
        settle();
        check("redir_pc_next",  pc_next,               32'h0000_0200);
        check("redir_misalign", {31'd0, misalign_err}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        settle();
        check("flush_req",     {31'd0, imem_req}, 32'd0);
        check("flush_pc_next", pc_next,           32'h0000_0200);
        tick();
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1);
        settle();
        check("stale_pc_next", pc_next, 32'h0000_0200);
        tick();
        check("stale_valid", {31'd0, if_valid}, 32'd0);
        check("stale_pc",    pc,                32'h0000_0200);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        settle();
        check("post_flush_req",  {31'd0, imem_req}, 32'd1);
        check("post_flush_addr", imem_addr,         32'h0000_0200);
        tick();

        // Misaligned redirect in WAIT coinciding with a response: data dropped, trap.
        drive(1'b0, 1'b1, 32'h1111_1111, 1'b1, 32'h0000_0202, 1'b1);
        settle();
        check("trap_misalign", {31'd0, misalign_err}, 32'd1);
        check("trap_pc_next",  pc_next,               32'h0000_0100);
        tick();
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        settle();
        check("trap_misalign_off", {31'd0, misalign_err}, 32'd0);
        check("trap_valid",        {31'd0, if_valid},     32'd0);
        check("trap_req",          {31'd0, imem_req},     32'd1);
        check("trap_addr",         imem_addr,             32'h0000_0100);

        // Redirect from REQ to the last word; grant in the same cycle is ignored.
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        settle();
        check("wrap_redir_req", {31'd0, imem_req}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        settle();
        check("wrap_req",  {31'd0, imem_req}, 32'd1);
        check("wrap_addr", imem_addr,         32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b1, 32'h0000_0073, 1'b0, 32'd0, 1'b0);
        settle();
        check("wrap_pc_next", pc_next, 32'd0);
        tick();
        check("wrap_if_pc",  if_pc,             32'hFFFF_FFFC);
        check("wrap_instr",  if_instr,          32'h0000_0073);
        check("wrap_valid",  {31'd0, if_valid}, 32'd1);
        check("wrap_pc",     pc,                32'd0);

        // Move to 0x40, enter WAIT, then pulse reset.
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0040, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        settle();
        check("r40_addr", imem_addr, 32'h0000_0040);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        rst = 1'b1;
        settle();
        check("mid_rst_req",     {31'd0, imem_req}, 32'd0);
        check("mid_rst_valid",   {31'd0, if_valid}, 32'd0);
        check("mid_rst_pc_next", pc_next,           pc);
        check("mid_rst_instr",   if_instr,          32'd0);
        check("mid_rst_if_pc",   if_pc,             32'd0);
        tick();
        rst = 1'b0;
        // Late response after release must be ignored in REQ.
        drive(1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 32'd0, 1'b1);
        settle();
        check("late_req",     {31'd0, imem_req}, 32'd1);
        check("late_addr",    imem_addr,         32'd0);
        check("late_pc_next", pc_next,           32'd0);
        tick();
        check("late_valid", {31'd0, if_valid}, 32'd0);
        check("late_pc",    pc,                32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
